// File: rtl/pwm_cap_rc_multi.sv
// Multi-channel RC receiver PWM capture: synchroniser, glitch filter, width range check,
// per-channel signal-loss timeout, ch0 period measurement and registered failsafe flag.
module pwm_cap_rc_multi #(
  parameter int N_CH   = 6,
  parameter int WIDTH  = 15,
  parameter int FILT   = 2,
  parameter int MIN_US = 800,
  parameter int MAX_US = 2200,
  parameter int TMO_US = 25000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pwm_clk,
  input  logic                    rc_en_in,
  input  logic [N_CH-1:0]         pwm_in,
  output logic [N_CH*WIDTH-1:0]   pulse_width,
  output logic [WIDTH-1:0]        pulse_period,
  output logic [N_CH-1:0]         width_valid,
  output logic [N_CH-1:0]         new_sample,
  output logic [N_CH-1:0]         range_err,
  output logic                    failsafe
);

  localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int TW = $clog2(TMO_US + 1);
  localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W     = WIDTH'(MIN_US);
  localparam logic [WIDTH-1:0] MAX_W     = WIDTH'(MAX_US);
  localparam logic [TW-1:0]    TMO_MAX   = TW'(TMO_US);
  localparam logic [TW-1:0]    TMO_LAST  = TW'(TMO_US - 1);
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILT - 1);

  logic [1:0]      warm_reg;
  logic            warm;
  logic            rise0;
  logic [N_CH-1:0] valid_vec;
  logic [WIDTH-1:0] per_cnt_reg;
  logic            per_armed_reg;
  logic [WIDTH-1:0] period_reg;
  logic            failsafe_reg;

  // The synchroniser output only carries a real pin sample after two ticks.
  assign warm = (warm_reg == 2'd2);

  always_ff @(posedge clk) begin
    if (rst || !rc_en_in) begin
      warm_reg <= 2'd0;
    end else if (pwm_clk && !warm) begin
      warm_reg <= warm_reg + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic             sync1_reg, sync2_reg, filt_reg, filt_d_reg;
      logic             seen_low_reg, qual_reg, valid_reg, new_reg, err_reg;
      logic [FW-1:0]    fcnt_reg;
      logic [WIDTH-1:0] wcnt_reg, width_reg;
      logic [TW-1:0]    tmo_reg;
      logic             rise, fall, in_range, accept;

      assign rise     = filt_reg & ~filt_d_reg;
      assign fall     = ~filt_reg & filt_d_reg;
      assign in_range = (wcnt_reg >= MIN_W) && (wcnt_reg <= MAX_W);
      // A pulse counts only if its rising edge followed a genuinely sampled low level,
      // so pulses truncated by reset or disable are silently dropped.
      assign accept   = fall & qual_reg & in_range;

      always_ff @(posedge clk) begin
        if (rst || !rc_en_in) begin
          sync1_reg    <= 1'b0;
          sync2_reg    <= 1'b0;
          filt_reg     <= 1'b0;
          filt_d_reg   <= 1'b0;
          seen_low_reg <= 1'b0;
          qual_reg     <= 1'b0;
          valid_reg    <= 1'b0;
          new_reg      <= 1'b0;
          err_reg      <= 1'b0;
          fcnt_reg     <= '0;
          wcnt_reg     <= '0;
          tmo_reg      <= '0;
        end else begin
          new_reg <= 1'b0;
          err_reg <= 1'b0;
          if (pwm_clk) begin
            sync1_reg  <= pwm_in[gi];
            sync2_reg  <= sync1_reg;
            filt_d_reg <= filt_reg;
            if (sync2_reg == filt_reg) begin
              fcnt_reg <= '0;
            end else if (fcnt_reg == FILT_LAST) begin
              filt_reg <= sync2_reg;
              fcnt_reg <= '0;
            end else begin
              fcnt_reg <= fcnt_reg + 1'b1;
            end
            if (warm && !sync2_reg) seen_low_reg <= 1'b1;
            if (rise) qual_reg <= seen_low_reg;
            if (fall) begin
              wcnt_reg <= '0;
            end else if (filt_reg && wcnt_reg != CNT_MAX) begin
              wcnt_reg <= wcnt_reg + 1'b1;
            end
            new_reg <= accept;
            err_reg <= fall & qual_reg & ~in_range;
            if (accept) begin
              tmo_reg   <= '0;
              valid_reg <= 1'b1;
            end else begin
              if (tmo_reg != TMO_MAX) tmo_reg <= tmo_reg + 1'b1;
              if (tmo_reg == TMO_LAST) valid_reg <= 1'b0;
            end
          end
        end
      end

      // Last accepted width survives disable; only reset clears it.
      always_ff @(posedge clk) begin
        if (rst) begin
          width_reg <= '0;
        end else if (rc_en_in && pwm_clk && accept) begin
          width_reg <= wcnt_reg;
        end
      end

      assign pulse_width[gi*WIDTH +: WIDTH] = width_reg;
      assign new_sample[gi]  = new_reg;
      assign range_err[gi]   = err_reg;
      assign valid_vec[gi]   = valid_reg;

      if (gi == 0) begin : g_rise0
        assign rise0 = rise;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt_reg   <= '0;
      per_armed_reg <= 1'b0;
      period_reg    <= '0;
    end else if (!rc_en_in) begin
      per_cnt_reg   <= '0;
      per_armed_reg <= 1'b0;
    end else if (pwm_clk) begin
      if (rise0) begin
        if (per_armed_reg) begin
          period_reg <= (per_cnt_reg == CNT_MAX) ? CNT_MAX : per_cnt_reg + 1'b1;
        end
        per_cnt_reg   <= '0;
        per_armed_reg <= 1'b1;
      end else if (per_cnt_reg != CNT_MAX) begin
        per_cnt_reg <= per_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      failsafe_reg <= 1'b1;
    end else begin
      failsafe_reg <= !(&valid_vec) || !rc_en_in;
    end
  end

  assign pulse_period = period_reg;
  assign width_valid  = valid_vec;
  assign failsafe     = failsafe_reg;

endmodule
